// File: rtl/hbm_read_port_pkg.sv
// Shared constants for the HBM read path: default widths, AXI response codes,
// fixed single-beat AR attributes and the AR state type.
package hbm_read_port_pkg;

  localparam int DEF_HBM_AWIDTH = 28;
  localparam int DEF_HBM_DWIDTH = 512;

  // One beat is 64 bytes, so a word index becomes a byte address by this shift.
  localparam int BEAT_SHIFT = 6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] AR_LEN        = 8'd0;
  localparam logic [2:0] AR_SIZE       = 3'(BEAT_SHIFT);
  localparam logic [1:0] AR_BURST_INCR = 2'b01;

  typedef enum logic {
    AR_IDLE,
    AR_ISSUE
  } ar_state_e;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define what is valid,
  // and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // NOTE: every state register uses non-blocking assignment so all flops update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hbm_read_port.sv
// One HBM pseudo-channel read port: queues loader word indices, issues single-beat
// AXI reads under a credit limit and forwards returned beats in order.
module hbm_read_port
  import hbm_read_port_pkg::*;
#(
  parameter int                    HBM_AWIDTH      = DEF_HBM_AWIDTH,
  parameter int                    HBM_DWIDTH      = DEF_HBM_DWIDTH,
  parameter int                    AXI_AWIDTH      = 33,
  parameter logic [AXI_AWIDTH-1:0] BASE_ADDR       = '0,
  parameter int                    FIFO_DEPTH      = 16,
  parameter int                    MAX_OUTSTANDING = 32
) (
  input  logic                  clk,
  input  logic                  bram_rst,
  input  logic [HBM_AWIDTH-1:0] loader_addr,
  input  logic                  loader_addr_valid,
  output logic                  loader_full,
  output logic [HBM_DWIDTH-1:0] loader_data,
  output logic                  loader_data_valid,
  output logic [AXI_AWIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [HBM_DWIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  output logic                  err_resp,
  output logic                  err_unexpected
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [HBM_AWIDTH-1:0] fifo_dout;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      count_next;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_pop;
  logic                  push_ok;

  ar_state_e             state_q;
  ar_state_e             state_d;
  logic [OUT_W-1:0]      outstanding;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  r_ok;
  logic                  room_now;
  logic                  room_after_issue;
  logic                  unused_rlast;

  sync_fifo #(
    .WIDTH (HBM_AWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_fifo (
    .clk   (clk),
    .rst   (bram_rst),
    .push  (loader_addr_valid),
    .din   (loader_addr),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign axi_arlen    = AR_LEN;
  assign axi_arsize   = AR_SIZE;
  assign axi_arburst  = AR_BURST_INCR;
  assign axi_rready   = 1'b1;
  assign axi_arvalid  = state_q == AR_ISSUE;
  assign unused_rlast = axi_rlast;

  assign ar_hs = axi_arvalid && axi_arready;
  assign r_hs  = axi_rvalid;
  assign r_ok  = r_hs && (outstanding != '0);

  // The AR currently being presented will hold a credit once accepted, so a
  // back-to-back pop must leave room for it as well.
  assign room_now         = int'(outstanding) < MAX_OUTSTANDING;
  assign room_after_issue = int'(outstanding) + 1 < MAX_OUTSTANDING;

  // Full is registered, so it is computed from the occupancy after this edge;
  // two entries of slack absorb pushes already committed by the loader.
  assign push_ok    = loader_addr_valid && (!fifo_full || fifo_pop);
  assign count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(fifo_pop);

  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      AR_IDLE: begin
        if (!fifo_empty && room_now) begin
          fifo_pop = 1'b1;
          state_d  = AR_ISSUE;
        end
      end
      AR_ISSUE: begin
        if (axi_arready) begin
          if (!fifo_empty && room_after_issue) fifo_pop = 1'b1;
          else                                 state_d  = AR_IDLE;
        end
      end
      default: state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bram_rst) begin
      state_q     <= AR_IDLE;
      axi_araddr  <= '0;
      loader_full <= 1'b0;
    end else begin
      state_q     <= state_d;
      loader_full <= count_next >= CNT_W'(FIFO_DEPTH - 2);
      if (fifo_pop)
        axi_araddr <= BASE_ADDR + (AXI_AWIDTH'(fifo_dout) << BEAT_SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (bram_rst) begin
      outstanding       <= '0;
      loader_data       <= '0;
      loader_data_valid <= 1'b0;
      err_resp          <= 1'b0;
      err_unexpected    <= 1'b0;
    end else begin
      case ({ar_hs, r_ok})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      loader_data_valid <= r_ok;
      if (r_ok) loader_data <= axi_rdata;
      if (r_ok && resp_is_error(axi_rresp)) err_resp <= 1'b1;
      // A beat with no read in flight is dropped without a valid pulse.
      if (r_hs && outstanding == '0) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hbm_read_port.sv
// Randomized and directed bench for hbm_read_port against a queue-based model of
// requested addresses, read credits and returned beats.
`timescale 1ns/1ps
module tb_hbm_read_port;
  import hbm_read_port_pkg::*;

  localparam int AW    = DEF_HBM_AWIDTH;
  localparam int DW    = 64;
  localparam int XW    = 33;
  localparam int DEPTH = 16;
  localparam int MAXO  = 32;
  localparam logic [XW-1:0] BASE = 33'h1_2345_6000;

  logic          clk = 1'b0;
  logic          bram_rst = 1'b0;
  logic [AW-1:0] loader_addr = '0;
  logic          loader_addr_valid = 1'b0;
  logic          loader_full;
  logic [DW-1:0] loader_data;
  logic          loader_data_valid;
  logic [XW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          axi_arready = 1'b0;
  logic [DW-1:0] axi_rdata = '0;
  logic [1:0]    axi_rresp = RESP_OKAY;
  logic          axi_rlast = 1'b1;
  logic          axi_rvalid = 1'b0;
  logic          axi_rready;
  logic          err_resp;
  logic          err_unexpected;

  hbm_read_port #(
    .HBM_AWIDTH      (AW),
    .HBM_DWIDTH      (DW),
    .AXI_AWIDTH      (XW),
    .BASE_ADDR       (BASE),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk               (clk),
    .bram_rst          (bram_rst),
    .loader_addr       (loader_addr),
    .loader_addr_valid (loader_addr_valid),
    .loader_full       (loader_full),
    .loader_data       (loader_data),
    .loader_data_valid (loader_data_valid),
    .axi_araddr        (axi_araddr),
    .axi_arlen         (axi_arlen),
    .axi_arsize        (axi_arsize),
    .axi_arburst       (axi_arburst),
    .axi_arvalid       (axi_arvalid),
    .axi_arready       (axi_arready),
    .axi_rdata         (axi_rdata),
    .axi_rresp         (axi_rresp),
    .axi_rlast         (axi_rlast),
    .axi_rvalid        (axi_rvalid),
    .axi_rready        (axi_rready),
    .err_resp          (err_resp),
    .err_unexpected    (err_unexpected)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Model state: addresses accepted but not yet seen on AR, credits in use,
  // and what the beat output must show after the next edge.
  logic [XW-1:0] addr_q[$];
  int            mout       = 0;
  bit            exp_v      = 1'b0;
  logic [DW-1:0] exp_d      = '0;
  bit            exp_eresp  = 1'b0;
  bit            exp_eun    = 1'b0;
  int            ar_count   = 0;
  int            beat_count = 0;

  function automatic logic [XW-1:0] addr_of(input logic [AW-1:0] idx);
    logic [63:0] a;
    a = 64'(BASE) + 64'(idx) * 64;
    return a[XW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  // Called at a falling edge: drive inputs, predict the coming rising edge,
  // then check the outputs at the following falling edge.
  task automatic step(input bit rst, input bit push, input logic [AW-1:0] idx,
                      input bit arr, input bit rv, input logic [DW-1:0] rd,
                      input logic [1:0] rr);
    bit nv;
    bram_rst          = rst;
    loader_addr_valid = push;
    loader_addr       = idx;
    axi_arready       = arr;
    axi_rvalid        = rv;
    axi_rdata         = rd;
    axi_rresp         = rr;
    nv = 1'b0;
    if (rst) begin
      addr_q.delete();
      mout      = 0;
      exp_d     = '0;
      exp_eresp = 1'b0;
      exp_eun   = 1'b0;
    end else begin
      if (axi_arvalid && arr) begin
        if (addr_q.size() == 0) begin
          check("ar_spurious", 64'(axi_araddr), 64'hdead);
        end else begin
          check("araddr", 64'(axi_araddr), 64'(addr_q.pop_front()));
          check("ar_attr", 64'({axi_arlen, axi_arsize, axi_arburst}),
                64'({8'd0, 3'd6, 2'b01}));
        end
        ar_count++;
      end
      if (rv) begin
        if (mout > 0) begin
          nv    = 1'b1;
          exp_d = rd;
          mout--;
          if (rr != RESP_OKAY) exp_eresp = 1'b1;
        end else begin
          exp_eun = 1'b1;
        end
      end
      if (axi_arvalid && arr) mout++;
      if (mout > MAXO) check("credit_limit", 64'(mout), 64'(MAXO));
      if (push) addr_q.push_back(addr_of(idx));
    end
    exp_v = nv;
    @(negedge clk);
    bram_rst = 1'b0;
    check("data_valid", 64'(loader_data_valid), 64'(exp_v));
    check("data", 64'(loader_data), 64'(exp_d));
    check("err_resp", 64'(err_resp), 64'(exp_eresp));
    check("err_unexpected", 64'(err_unexpected), 64'(exp_eun));
    if (loader_data_valid) beat_count++;
    if (rst) begin
      check("rst_arvalid", 64'(axi_arvalid), 64'd0);
      check("rst_full", 64'(loader_full), 64'd0);
    end
  endtask

  task automatic idle_step(input bit arr);
    step(1'b0, 1'b0, '0, arr, 1'b0, '0, RESP_OKAY);
  endtask

  task automatic reset_step();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, RESP_OKAY);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && !(addr_q.size() == 0 && mout == 0); i++)
      step(1'b0, 1'b0, '0, 1'b1, (mout > 0) && ($urandom_range(3) != 0),
           rand_data(), RESP_OKAY);
    check({tag, "_drained"}, 64'(addr_q.size() + mout), 64'd0);
  endtask

  // Withhold R and keep the queue fed until AR issue stops; the credits seen
  // on the bus must then equal the limit exactly.
  task automatic fill_to_cap(input string tag, input int max_push);
    int pushed;
    pushed = 0;
    for (int i = 0; i < 150; i++) begin
      bit p;
      p = !loader_full && (pushed < max_push);
      step(1'b0, p, AW'(1000 + i), 1'b1, 1'b0, '0, RESP_OKAY);
      if (p) pushed++;
    end
    check({tag, "_credits"}, 64'(mout), 64'(MAXO));
    check({tag, "_arvalid"}, 64'(axi_arvalid), 64'd0);
    check({tag, "_queued"}, 64'(addr_q.size() > 0), 64'd1);
  endtask

  initial begin
    int a0, b0, sent;
    @(negedge clk);

    // Four consecutive addresses, immediate AR acceptance, SLVERR on beat 2.
    reset_step();
    check("rready_const", 64'(axi_rready), 64'd1);
    a0 = ar_count; b0 = beat_count; sent = 0;
    for (int i = 0; i < 14; i++) begin
      bit rv;
      rv = (mout > 0);
      step(1'b0, i < 4, AW'(i), 1'b1, rv, rand_data(),
           (rv && sent == 1) ? RESP_SLVERR : RESP_OKAY);
      if (rv) sent++;
    end
    check("basic_ar_count", 64'(ar_count - a0), 64'd4);
    check("basic_beats", 64'(beat_count - b0), 64'd4);
    check("basic_err_sticky", 64'(err_resp), 64'd1);

    // AR stalled while the loader streams; full must rise at occupancy 14.
    reset_step();
    a0 = ar_count;
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 1'b1, AW'($urandom), 1'b0, 1'b0, '0, RESP_OKAY);
      if (k == 14) check("full_at_13", 64'(loader_full), 64'd0);
      if (k == 15) check("full_at_14", 64'(loader_full), 64'd1);
    end
    for (int k = 0; k < 3; k++) idle_step(1'b0);
    check("full_held", 64'(loader_full), 64'd1);
    drain("stall");
    check("stall_ar_count", 64'(ar_count - a0), 64'd17);
    check("stall_full_clear", 64'(loader_full), 64'd0);

    // Credit limit: exactly one further AR per returned beat.
    reset_step();
    fill_to_cap("cap", 40);
    a0 = ar_count;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, rand_data(), RESP_OKAY);
    for (int k = 0; k < 8; k++) idle_step(1'b1);
    check("cap_one_more_ar", 64'(ar_count - a0), 64'd1);
    drain("cap");

    // Same-cycle AR and R handshakes at five credits in use.
    reset_step();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, '0, RESP_OKAY);
    for (int i = 0; i < 10 && mout < 5; i++) idle_step(1'b1);
    check("five_credits", 64'(mout), 64'd5);
    step(1'b0, 1'b1, AW'(77), 1'b0, 1'b0, '0, RESP_OKAY);
    for (int i = 0; i < 6 && !axi_arvalid; i++) idle_step(1'b0);
    check("arvalid_before_both", 64'(axi_arvalid), 64'd1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, rand_data(), RESP_OKAY);
    fill_to_cap("both", 40);
    drain("both");

    // Reset mid-operation with 8 queued and 4 in flight; late beats are stray.
    reset_step();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, '0, RESP_OKAY);
    for (int i = 0; i < 10 && mout < 4; i++) idle_step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, AW'(50 + i), 1'b0, 1'b0, '0, RESP_OKAY);
    check("pre_rst_credits", 64'(mout), 64'd4);
    reset_step();
    a0 = ar_count; b0 = beat_count;
    for (int i = 0; i < 4; i++) idle_step(1'b1);
    check("post_rst_no_ar", 64'(ar_count - a0), 64'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, rand_data(), RESP_OKAY);
    idle_step(1'b1);
    check("stray_no_beat", 64'(beat_count - b0), 64'd0);
    check("stray_flag", 64'(err_unexpected), 64'd1);

    // Random traffic.
    reset_step();
    for (int i = 0; i < 1500; i++) begin
      bit p, rv;
      p  = ($urandom_range(2) != 0) && !loader_full;
      rv = (mout > 0) && ($urandom_range(1) == 1);
      step(1'b0, p, AW'($urandom), $urandom_range(3) != 0, rv, rand_data(),
           ($urandom_range(7) == 0) ? 2'($urandom) : RESP_OKAY);
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hbm_read_port.md
HBM_READ_PORT -- requirements
Module: hbm_read_port

Interface
REQ-001 Parameter HBM_AWIDTH, default `HBM_AWIDTH: width of the word index from the loader address generator.
REQ-002 Parameter HBM_DWIDTH, default `HBM_DWIDTH (512): data beat width.
REQ-003 Parameter AXI_AWIDTH, default 33: AXI byte-address width.
REQ-004 Parameter BASE_ADDR, default 0: pseudo-channel byte base address.
REQ-005 Parameter FIFO_DEPTH, default 16 (power of 2, >=4): address FIFO depth.
REQ-006 Parameter MAX_OUTSTANDING, default 32: AXI read-credit limit.
REQ-007 clk  in  1  single clock; all logic rising-edge.
REQ-008 bram_rst  in  1  synchronous, active-high reset.
REQ-009 loader_addr  in  HBM_AWIDTH  word index from loader.
REQ-010 loader_addr_valid  in  1  loader_addr valid this cycle; no ready, must never be dropped.
REQ-011 loader_full  out  1  back-pressure to loader.
REQ-012 loader_data  out  HBM_DWIDTH  returned beat to dispatcher.
REQ-013 loader_data_valid  out  1  loader_data valid; single-cycle pulse per beat.
REQ-014 axi_araddr out AXI_AWIDTH; axi_arlen out 8; axi_arsize out 3; axi_arburst out 2; axi_arvalid out 1; axi_arready in 1.
REQ-015 axi_rdata in HBM_DWIDTH; axi_rresp in 2; axi_rlast in 1; axi_rvalid in 1; axi_rready out 1.
REQ-016 err_resp  out  1  sticky: a non-OKAY rresp was received.
REQ-017 err_unexpected  out  1  sticky: R beat received with zero reads outstanding.

Function
REQ-018 Address FIFO SHALL push loader_addr every cycle loader_addr_valid=1, independent of loader_full.
REQ-019 loader_full SHALL be registered; 1 when next-cycle fifo_count >= FIFO_DEPTH-2 (2-entry slack covers loader's registered valid).
REQ-020 AR FSM states IDLE, ISSUE; IDLE->ISSUE when FIFO non-empty and outstanding < MAX_OUTSTANDING, popping head into araddr register.
REQ-021 In ISSUE, axi_arvalid=1 and araddr SHALL stay stable until axi_arready=1; then ->IDLE, or pop next entry and remain in ISSUE if eligible (back-to-back, one AR per cycle).
REQ-022 axi_araddr = BASE_ADDR + (index << 6), truncated to AXI_AWIDTH; arlen=0, arsize=3'd6, arburst=2'b01, constant.
REQ-023 Outstanding counter: +1 on AR handshake, -1 on R handshake, unchanged if both same cycle; never exceeds MAX_OUTSTANDING.
REQ-024 axi_rready SHALL be constant 1 (downstream has no back-pressure).
REQ-025 On R handshake with outstanding>0: loader_data<=rdata and loader_data_valid<=1 next cycle (1-cycle latency); otherwise loader_data_valid<=0, loader_data holds.
REQ-026 Non-OKAY rresp SHALL set err_resp and still forward the beat.
REQ-027 R beat with outstanding=0 SHALL be discarded (no valid pulse) and set err_unexpected.
REQ-028 Push to a full FIFO SHALL not occur under REQ-019; simultaneous push and pop SHALL leave count unchanged.
REQ-029 Return order SHALL equal request order (single ID, AXI in-order).

Reset
REQ-030 bram_rst SHALL clear: FIFO pointers/count, outstanding counter, FSM to IDLE, axi_arvalid=0, loader_data=0, loader_data_valid=0, loader_full=0, err_resp=0, err_unexpected=0.
REQ-031 Reset mid-operation SHALL abandon queued addresses; in-flight R beats arriving after reset SHALL follow REQ-027.

Structure
REQ-032 HBM_AWIDTH, HBM_DWIDTH, AXI response codes and the 64-byte beat shift belong in shared header accelerator.vh.
REQ-033 Address FIFO SHALL be sub-module sync_fifo (parameterised width/depth, count output); one hbm_read_port per pseudo channel.

Verification
REQ-034 Reset, then addrs 0..3 on consecutive cycles, arready=1, R 2 cycles later -> araddr BASE+0x0,0x40,0x80,0xC0; four data pulses in order.
REQ-035 arready=0 for 20 cycles while loader streams -> loader_full=1 once count reaches 14; no address lost; all issue after arready=1.
REQ-036 Withhold R until 32 ARs issued -> arvalid stays 0 with FIFO non-empty; one R returns -> exactly one further AR.
REQ-037 Same-cycle AR and R handshake at outstanding=5 -> outstanding stays 5.
REQ-038 rresp=2'b10 on beat 2 -> err_resp=1 sticky, beat 2 still forwarded; R beat after reset -> err_unexpected=1, no valid pulse.
REQ-039 bram_rst asserted with 8 queued, 4 outstanding -> all outputs at reset values next cycle; FIFO empty.
